// File: rtl/pipeline_types.sv
// rtl/pipeline_types.sv - shared pipeline types: control path, enable modes, generator states
package pipeline_types;

    typedef struct packed {
        logic rising;
    } control_path_t;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_FREE  = 2'd1,
        MODE_BURST = 2'd2
    } enable_mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BURST = 2'd2
    } gen_state_e;

    // The unused encoding 3 behaves exactly like MODE_OFF.
    function automatic logic mode_is_off(input enable_mode_e mode);
        return (mode != MODE_FREE) && (mode != MODE_BURST);
    endfunction

endpackage

// File: rtl/enable_phase_core.sv
// rtl/enable_phase_core.sv - phase counter with wrap detect and resync
module enable_phase_core #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_effdiv,
    input  logic             i_rising,
    output logic [CNT_W-1:0] o_phase,
    output logic             o_wrap
);

    logic [CNT_W-1:0] r_phase;
    logic             w_last;

    assign w_last = !(r_phase < (i_effdiv - CNT_W'(1)));

    // Resync wins over a coincident wrap: phase restarts and no enable is produced.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_phase <= '0;
        end else if (!i_run || i_rising || w_last) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + CNT_W'(1);
        end
    end

    assign o_wrap  = i_run && !i_rising && w_last;
    assign o_phase = r_phase;

endmodule

// File: rtl/count_enable_gen.sv
// rtl/count_enable_gen.sv - programmable count-enable generator; COUNT_ENABLE_GEN_DRIFT_EN adds phase-drift reporting
module count_enable_gen
    import pipeline_types::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  control_path_t    i_control,
    input  enable_mode_e     i_mode,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_div_load,
    input  logic [CNT_W-1:0] i_burst_len,
    input  logic             i_burst_start,
    output logic             o_count_enable,
    output logic [CNT_W-1:0] o_phase,
    output logic [CNT_W-1:0] o_div_active,
    output logic             o_busy
`ifdef COUNT_ENABLE_GEN_DRIFT_EN
    ,
    output logic [CNT_W-1:0] o_drift,
    output logic             o_drift_valid
`endif
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    gen_state_e       r_state, w_state_next;
    logic [CNT_W-1:0] r_div_active, r_shadow, r_remaining;
    logic [CNT_W-1:0] w_effdiv, w_phase;
    logic             r_pending, r_en;
    logic             w_run, w_wrap, w_resync, w_commit, w_mode_off, w_burst_go;

    assign w_mode_off = mode_is_off(i_mode);
    assign w_burst_go = (i_mode == MODE_BURST) && i_burst_start && (i_burst_len != '0);
    assign w_effdiv   = (r_div_active == '0) ? CNT_W'(1) : r_div_active;

    // The core only counts on cycles where the current state is going to persist.
    assign w_run = ((r_state == S_RUN) && (i_mode == MODE_FREE)) ||
                   ((r_state == S_BURST) && !w_mode_off && (r_remaining != '0));
    assign w_resync = w_run && i_control.rising;
    assign w_commit = r_pending && ((r_state == S_IDLE) || w_wrap || w_resync);

    enable_phase_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_run     (w_run),
        .i_effdiv  (w_effdiv),
        .i_rising  (i_control.rising),
        .o_phase   (w_phase),
        .o_wrap    (w_wrap)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_mode == MODE_FREE) begin
                    w_state_next = S_RUN;
                end else if (w_burst_go) begin
                    w_state_next = S_BURST;
                end
            end
            S_RUN: begin
                if (i_mode != MODE_FREE) begin
                    w_state_next = S_IDLE;
                end
            end
            S_BURST: begin
                if (w_mode_off || (r_remaining == '0)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_en    <= w_wrap;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_remaining <= '0;
        end else if ((r_state == S_IDLE) && (w_state_next == S_BURST)) begin
            r_remaining <= i_burst_len;
        end else if (r_state == S_BURST) begin
            if (w_mode_off) begin
                r_remaining <= '0;
            end else if (w_wrap) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    // A load coinciding with a commit keeps the new value pending behind the older one.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_div_active <= DEF_DIV;
            r_shadow     <= DEF_DIV;
            r_pending    <= 1'b0;
        end else begin
            if (w_commit) begin
                r_div_active <= r_shadow;
            end
            if (i_div_load) begin
                r_shadow  <= i_div;
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

`ifdef COUNT_ENABLE_GEN_DRIFT_EN
    logic [CNT_W-1:0] r_drift;
    logic             r_drift_valid;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_drift       <= '0;
            r_drift_valid <= 1'b0;
        end else begin
            r_drift_valid <= w_resync;
            if (w_resync) begin
                r_drift <= w_phase;
            end
        end
    end

    assign o_drift       = r_drift;
    assign o_drift_valid = r_drift_valid;
`endif

    assign o_count_enable = r_en;
    assign o_phase        = w_phase;
    assign o_div_active   = r_div_active;
    assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_count_enable_gen.sv
// tb/tb_count_enable_gen.sv - self-checking bench for count_enable_gen
module tb_count_enable_gen;
    import pipeline_types::*;

    localparam int CNT_W = 16;

    logic             i_clk = 1'b0;
    logic             i_reset_n;
    control_path_t    i_control;
    enable_mode_e     i_mode;
    logic [CNT_W-1:0] i_div;
    logic             i_div_load;
    logic [CNT_W-1:0] i_burst_len;
    logic             i_burst_start;
    logic             o_count_enable;
    logic [CNT_W-1:0] o_phase;
    logic [CNT_W-1:0] o_div_active;
    logic             o_busy;
`ifdef COUNT_ENABLE_GEN_DRIFT_EN
    logic [CNT_W-1:0] o_drift;
    logic             o_drift_valid;
`endif

    count_enable_gen #(.CNT_W(CNT_W), .DEFAULT_DIV(5)) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_control      (i_control),
        .i_mode         (i_mode),
        .i_div          (i_div),
        .i_div_load     (i_div_load),
        .i_burst_len    (i_burst_len),
        .i_burst_start  (i_burst_start),
        .o_count_enable (o_count_enable),
        .o_phase        (o_phase),
        .o_div_active   (o_div_active),
        .o_busy         (o_busy)
`ifdef COUNT_ENABLE_GEN_DRIFT_EN
        ,
        .o_drift        (o_drift),
        .o_drift_valid  (o_drift_valid)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model state: activity (0 idle, 1 free-run, 2 burst), cycles into the period, divisors, bursts left.
    typedef struct packed {
        int st;
        int phase;
        int div;
        int shadow;
        bit pend;
        int left;
        bit en;
        int drift;
        bit dvalid;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(input mstate_t s);
        mstate_t n = s;
        int  period;
        bit  off, counting, resync, period_done;
        period      = (s.div == 0) ? 1 : s.div;
        off         = !(i_mode == MODE_FREE || i_mode == MODE_BURST);
        counting    = (s.st == 1 && i_mode == MODE_FREE) || (s.st == 2 && !off && s.left > 0);
        resync      = counting && i_control.rising;
        period_done = counting && (s.phase + 1 == period);
        n.en        = period_done && !resync;
        n.phase     = (counting && !resync) ? (s.phase + 1) % period : 0;
        if (s.pend && (s.st == 0 || resync || period_done)) begin
            n.div  = s.shadow;
            n.pend = 1'b0;
        end
        if (i_div_load) begin
            n.shadow = int'(i_div);
            n.pend   = 1'b1;
        end
        n.dvalid = resync;
        if (resync) n.drift = s.phase;
        if (s.st == 0) begin
            if (i_mode == MODE_FREE) n.st = 1;
            else if (i_mode == MODE_BURST && i_burst_start && i_burst_len != 0) begin
                n.st   = 2;
                n.left = int'(i_burst_len);
            end
        end else if (s.st == 1) begin
            if (i_mode != MODE_FREE) n.st = 0;
        end else begin
            if (off) begin
                n.st   = 0;
                n.left = 0;
            end else if (s.left == 0) n.st = 0;
            else if (n.en) n.left = s.left - 1;
        end
        return n;
    endfunction

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            m <= '{st: 0, phase: 0, div: 5, shadow: 5, pend: 1'b0, left: 0, en: 1'b0, drift: 0, dvalid: 1'b0};
        else
            m <= model_next(m);
    end

    always @(negedge i_clk) begin
        if (chk_on && i_reset_n) begin
            chk("model_enable", int'(o_count_enable), int'(m.en));
            chk("model_phase", int'(o_phase), m.phase);
            chk("model_div_active", int'(o_div_active), m.div);
            chk("model_busy", int'(o_busy), int'(m.st != 0));
`ifdef COUNT_ENABLE_GEN_DRIFT_EN
            chk("model_drift", int'(o_drift), m.drift);
            chk("model_drift_valid", int'(o_drift_valid), int'(m.dvalid));
`endif
        end
    end

    // Run n cycles, recording o_count_enable at each falling edge; strobes last one cycle.
    task automatic run_mask(input int n, output logic [31:0] mask);
        mask = '0;
        for (int j = 0; j < n; j++) begin
            @(negedge i_clk);
            mask[j]          = o_count_enable;
            i_div_load       = 1'b0;
            i_burst_start    = 1'b0;
            i_control.rising = 1'b0;
        end
    endtask

    logic [31:0] mk;

    initial begin
        i_reset_n        = 1'b0;
        i_control.rising = 1'b0;
        i_mode           = MODE_OFF;
        i_div            = '0;
        i_div_load       = 1'b0;
        i_burst_len      = '0;
        i_burst_start    = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("reset_enable", int'(o_count_enable), 0);
        chk("reset_phase", int'(o_phase), 0);
        chk("reset_div_active", int'(o_div_active), 5);
        chk("reset_busy", int'(o_busy), 0);
        i_reset_n = 1'b1;
        chk_on    = 1'b1;

        // Free run at the default divisor: first enable five cycles after entry.
        i_mode = MODE_FREE;
        run_mask(12, mk);
        chk("free_div5_pulses", int'(mk), 32'h420);
        chk("free_phase_before_load", int'(o_phase), 1);

        // Divisor 3 loaded at phase 1 takes effect only at the wrap.
        i_div      = 16'd3;
        i_div_load = 1'b1;
        run_mask(10, mk);
        chk("div3_switch_pulses", int'(mk), 32'h248);
        chk("div3_active", int'(o_div_active), 3);

        i_div      = 16'd4;
        i_div_load = 1'b1;
        run_mask(5, mk);
        chk("div4_switch_pulses", int'(mk), 32'h4);
        chk("div4_phase_at_resync", int'(o_phase), 2);
        chk("div4_active", int'(o_div_active), 4);

        // Resync at phase 2 restarts the period.
        i_control.rising = 1'b1;
        run_mask(5, mk);
        chk("resync_mid_pulses", int'(mk), 32'h10);
`ifdef COUNT_ENABLE_GEN_DRIFT_EN
        chk("resync_mid_drift", int'(o_drift), 2);
`endif

        // Resync on the wrap cycle suppresses that enable.
        run_mask(3, mk);
        chk("pre_wrap_quiet", int'(mk), 0);
        chk("wrap_phase", int'(o_phase), 3);
        i_control.rising = 1'b1;
        run_mask(5, mk);
        chk("resync_wrap_pulses", int'(mk), 32'h10);
`ifdef COUNT_ENABLE_GEN_DRIFT_EN
        chk("resync_wrap_drift", int'(o_drift), 3);
`endif

        // Burst of 3 at divisor 2; a second start mid-burst must be ignored.
        i_mode = MODE_OFF;
        run_mask(2, mk);
        chk("off_quiet", int'(mk), 0);
        chk("off_busy", int'(o_busy), 0);
        i_div      = 16'd2;
        i_div_load = 1'b1;
        run_mask(2, mk);
        chk("idle_commit_div2", int'(o_div_active), 2);
        i_mode        = MODE_BURST;
        i_burst_len   = 16'd3;
        i_burst_start = 1'b1;
        run_mask(3, mk);
        chk("burst_first_pulse", int'(mk), 32'h4);
        chk("burst_busy", int'(o_busy), 1);
        i_burst_start = 1'b1;
        run_mask(6, mk);
        chk("burst_rest_pulses", int'(mk), 32'ha);
        chk("burst_done_busy", int'(o_busy), 0);

        // Divisor 0 means an enable every cycle; mode 3 behaves as off.
        i_div      = 16'd0;
        i_div_load = 1'b1;
        run_mask(2, mk);
        chk("div0_active", int'(o_div_active), 0);
        i_mode = MODE_FREE;
        run_mask(6, mk);
        chk("div0_pulses", int'(mk), 32'h3e);
        i_mode = enable_mode_e'(2'd3);
        run_mask(3, mk);
        chk("mode3_quiet", int'(mk), 0);
        chk("mode3_busy", int'(o_busy), 0);
        i_mode        = MODE_BURST;
        i_burst_len   = 16'd0;
        i_burst_start = 1'b1;
        run_mask(3, mk);
        chk("burst_len0_quiet", int'(mk), 0);
        chk("burst_len0_busy", int'(o_busy), 0);

        // Reset mid-burst with a pending divisor.
        i_div      = 16'd3;
        i_div_load = 1'b1;
        run_mask(2, mk);
        i_burst_len   = 16'd10;
        i_burst_start = 1'b1;
        run_mask(4, mk);
        chk("burst10_pulses", int'(mk), 32'h8);
        i_div      = 16'd7;
        i_div_load = 1'b1;
        run_mask(1, mk);
        chk("pending_not_active", int'(o_div_active), 3);
        #2 i_reset_n = 1'b0;
        #1;
        chk("midreset_enable", int'(o_count_enable), 0);
        chk("midreset_phase", int'(o_phase), 0);
        chk("midreset_div_active", int'(o_div_active), 5);
        chk("midreset_busy", int'(o_busy), 0);
        i_mode = MODE_OFF;
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        i_mode    = MODE_FREE;
        run_mask(11, mk);
        chk("post_reset_pulses", int'(mk), 32'h420);
        chk("post_reset_div_active", int'(o_div_active), 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
